// File: rtl/spi_master_arbiter_if.sv
// spi_master_arbiter_if: requester handshake plus shared SPI bus between the arbiter and its environment
interface spi_master_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int NUM_SLV = 4,
    parameter int SLV_W   = $clog2(NUM_SLV)
);
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*SLV_W-1:0] req_slv;
    logic [NUM_REQ*8-1:0]     req_data;
    logic [NUM_REQ-1:0]       grant;
    logic                     done;
    logic [7:0]               rx_data;
    logic                     busy;
    logic                     SCLK;
    logic [NUM_SLV-1:0]       CS;
    logic                     MOSI;
    logic                     MISO;
    modport master (
        input  req, req_slv, req_data, MISO,
        output grant, done, rx_data, busy, SCLK, CS, MOSI
    );
    modport slave (
        output req, req_slv, req_data, MISO,
        input  grant, done, rx_data, busy, SCLK, CS, MOSI
    );
endinterface

// File: rtl/spi_master_arbiter.sv
// spi_master_arbiter: round-robin arbiter driving one LSB-first SPI master, with a CS-high flush clock after each byte
module spi_master_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int NUM_SLV = 4,
    parameter int CLK_DIV = 2,
    parameter int SLV_W   = $clog2(NUM_SLV)
) (
    input logic clk,
    input logic reset,
    spi_master_arbiter_if.master bus
);
    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int DIV_W = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
    typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, FLUSH_HIGH, FLUSH_LOW, DONE} state_t;
    state_t state, state_n;
    logic [PTR_W-1:0] ptr, ptr_n, gidx, gidx_n, win;
    logic [DIV_W-1:0] div, div_n;
    logic [2:0] bit_cnt, bit_n;
    logic [7:0] tx, tx_n, rx_sh, rx_sh_n, rx_n;
    logic [NUM_REQ-1:0] grant_n;
    logic [NUM_SLV-1:0] cs_n;
    logic done_n, sclk_n, mosi_n, wrap;
    assign wrap = div == DIV_W'(CLK_DIV - 1);
    assign bus.busy = state != IDLE;
    // scan downward so the closest set request at or after ptr wins
    always_comb begin
        win = ptr;
        for (int i = NUM_REQ - 1; i >= 0; i--)
            if (bus.req[(int'(ptr) + i) % NUM_REQ]) win = PTR_W'((int'(ptr) + i) % NUM_REQ);
    end
    always_comb begin
        state_n = state;
        div_n = (state == IDLE || state == DONE || wrap) ? '0 : div + 1'b1;
        ptr_n = ptr;
        gidx_n = gidx;
        bit_n = bit_cnt;
        tx_n = tx;
        rx_sh_n = rx_sh;
        rx_n = bus.rx_data;
        grant_n = bus.grant;
        done_n = 1'b0;
        sclk_n = bus.SCLK;
        cs_n = bus.CS;
        mosi_n = bus.MOSI;
        case (state)
            IDLE: if (|bus.req) begin
                state_n = SETUP;
                gidx_n = win;
                grant_n = NUM_REQ'(1) << win;
                tx_n = bus.req_data[int'(win)*8 +: 8];
                cs_n = ~(NUM_SLV'(1) << bus.req_slv[int'(win)*SLV_W +: SLV_W]);
                mosi_n = tx_n[0];
                bit_n = '0;
            end
            SETUP: if (wrap) begin
                state_n = HIGH;
                sclk_n = 1'b1;
            end
            HIGH: if (wrap) begin
                state_n = LOW;
                sclk_n = 1'b0;
                rx_sh_n = {bus.MISO, rx_sh[7:1]};
                mosi_n = tx[1];
                tx_n = tx >> 1;
            end
            // CS releases on the same edge as the flush rise, so the slave sees that rise deselected
            LOW: if (wrap) begin
                state_n = bit_cnt == 3'd7 ? FLUSH_HIGH : HIGH;
                cs_n = bit_cnt == 3'd7 ? '1 : bus.CS;
                sclk_n = 1'b1;
                bit_n = bit_cnt + 1'b1;
            end
            FLUSH_HIGH: if (wrap) begin
                state_n = FLUSH_LOW;
                sclk_n = 1'b0;
            end
            FLUSH_LOW: if (wrap) state_n = DONE;
            DONE: begin
                state_n = IDLE;
                done_n = 1'b1;
                rx_n = rx_sh;
                grant_n = '0;
                ptr_n = gidx == PTR_W'(NUM_REQ - 1) ? '0 : gidx + 1'b1;
            end
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            div <= '0;
            ptr <= '0;
            gidx <= '0;
            bit_cnt <= '0;
            tx <= '0;
            rx_sh <= '0;
            bus.rx_data <= '0;
            bus.grant <= '0;
            bus.done <= 1'b0;
            bus.SCLK <= 1'b0;
            bus.CS <= '1;
            bus.MOSI <= 1'b0;
        end else begin
            state <= state_n;
            div <= div_n;
            ptr <= ptr_n;
            gidx <= gidx_n;
            bit_cnt <= bit_n;
            tx <= tx_n;
            rx_sh <= rx_sh_n;
            bus.rx_data <= rx_n;
            bus.grant <= grant_n;
            bus.done <= done_n;
            bus.SCLK <= sclk_n;
            bus.CS <= cs_n;
            bus.MOSI <= mosi_n;
        end
    end
endmodule

// File: tb/tb_spi_master_arbiter.sv
// tb_spi_master_arbiter: directed and random traffic against a transfer-level model and a behavioural SPI slave
module tb_spi_master_arbiter;
    localparam int NR = 2, NS = 4, D = 2, SW = 2, RSW = NR * SW;
    logic clk = 1'b0, reset = 1'b0;
    int tests = 0, fails = 0;
    spi_master_arbiter_if #(.NUM_REQ(NR), .NUM_SLV(NS)) bus();
    spi_master_arbiter #(.NUM_REQ(NR), .NUM_SLV(NS), .CLK_DIV(D)) dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // slave: drives MISO LSB first on each rise, re-arms on a rise with CS high
    logic [7:0] slv_byte [NS];
    int s_cnt = 0, rises = 0, last_rises = 0, flush_rises = 0;
    logic [7:0] mosi_sr = '0, last_mosi = '0;
    initial forever begin
        @(posedge bus.SCLK or negedge reset);
        if (!reset) begin
            s_cnt = 0;
            rises = 0;
            mosi_sr = '0;
        end else begin
            #1;
            if (&bus.CS) begin
                last_mosi = mosi_sr;
                last_rises = rises;
                rises = 0;
                s_cnt = 0;
                flush_rises++;
            end else begin
                for (int s = 0; s < NS; s++) if (!bus.CS[s]) bus.MISO = slv_byte[s][s_cnt % 8];
                mosi_sr = {bus.MOSI, mosi_sr[7:1]};
                rises++;
                s_cnt++;
            end
        end
    end

    logic pos_rst;
    logic [NR-1:0] s_req;
    logic [RSW-1:0] s_slv;
    logic [NR*8-1:0] s_data;
    always @(posedge clk) begin
        pos_rst <= reset;
        s_req <= bus.req;
        s_slv <= bus.req_slv;
        s_data <= bus.req_data;
    end

    // transfer-level model: k = clk edges since grant, h = half-period index within the transfer
    int m_act = 0, m_k = 0, m_w = 0, m_ptr = 0, h, bi;
    logic found, m_done = 1'b0;
    logic [SW-1:0] m_slv = '0;
    logic [7:0] m_dat = '0, m_rx = '0;
    logic [NR-1:0] e_grant, prev_grant = '0;
    logic [NS-1:0] e_cs, one_cs = NS'(1);
    logic e_sclk, e_mosi;
    logic [NR-1:0] dut_grants [$];
    initial forever begin
        @(negedge clk);
        if (!reset) begin
            m_act = 0; m_k = 0; m_ptr = 0; m_rx = '0; m_done = 1'b0;
        end else if (pos_rst) begin
            m_done = 1'b0;
            if (m_act != 0) begin
                if (m_k == 19 * D) begin
                    m_act = 0;
                    m_done = 1'b1;
                    m_rx = slv_byte[m_slv];
                    m_ptr = (m_w + 1) % NR;
                end else m_k++;
            end else if (s_req != '0) begin
                found = 1'b0;
                for (int i = 0; i < NR; i++)
                    if (!found && s_req[(m_ptr + i) % NR]) begin
                        found = 1'b1;
                        m_w = (m_ptr + i) % NR;
                    end
                m_slv = s_slv[m_w*SW +: SW];
                m_dat = s_data[m_w*8 +: 8];
                m_k = 0;
                m_act = 1;
            end
        end
        h = m_k / D;
        bi = h / 2;
        e_grant = m_act != 0 ? NR'(1) << m_w : '0;
        e_sclk = m_act != 0 && h % 2 == 1 && h <= 17;
        e_cs = (m_act != 0 && h <= 16) ? ~(one_cs << m_slv) : '1;
        e_mosi = (m_act != 0 && bi < 8) ? m_dat[bi % 8] : 1'b0;
        check("cmp_grant", bus.grant, e_grant);
        check("cmp_busy", bus.busy, m_act != 0);
        check("cmp_sclk", bus.SCLK, e_sclk);
        check("cmp_cs", bus.CS, e_cs);
        check("cmp_mosi", bus.MOSI, e_mosi);
        check("cmp_done", bus.done, m_done);
        check("cmp_rx", bus.rx_data, m_rx);
        if (bus.grant != '0 && prev_grant == '0) dut_grants.push_back(bus.grant);
        prev_grant = bus.grant;
    end

    task automatic wait_grant(input string nm);
        int n = 0;
        while (bus.grant == '0 && n < 100) begin @(negedge clk); n++; end
        check({nm, "_grant_timeout"}, 32'(bus.grant != '0), 1);
    endtask

    task automatic wait_done(input string nm, output int cyc);
        cyc = 0;
        do begin @(negedge clk); cyc++; end while (!bus.done && cyc < 400);
        check({nm, "_done_timeout"}, 32'(bus.done), 1);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        bus.req = '0;
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;
    endtask

    initial begin
        int lat, n, fl0;
        bus.req = '0; bus.req_slv = '0; bus.req_data = '0; bus.MISO = 1'b0;
        slv_byte[0] = 8'h17; slv_byte[1] = 8'hAA; slv_byte[2] = 8'h3C; slv_byte[3] = 8'hE4;
        @(negedge clk);
        check("rst_grant", bus.grant, 0);
        check("rst_done", bus.done, 0);
        check("rst_rx", bus.rx_data, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_sclk", bus.SCLK, 0);
        check("rst_cs", bus.CS, 4'hF);
        check("rst_mosi", bus.MOSI, 0);
        @(posedge clk); #2 reset = 1'b1;
        bus.req_slv[1:0] = 2'd2; bus.req_data[7:0] = 8'hA5; bus.req[0] = 1'b1;
        fl0 = flush_rises;
        wait_grant("t1");
        check("t1_grant", bus.grant, 2'b01);
        wait_done("t1", lat);
        #1 bus.req = '0;
        check("t1_latency", lat, 39);
        check("t1_rx", bus.rx_data, 8'h3C);
        check("t1_mosi", last_mosi, 8'hA5);
        check("t1_cs_rises", last_rises, 8);
        check("t1_flush_rise", flush_rises - fl0, 1);

        do_reset();
        bus.req_slv = {2'd1, 2'd3}; bus.req_data = {8'h96, 8'h69}; bus.req = 2'b11;
        dut_grants.delete();
        for (int i = 0; i < 4; i++) wait_done("rr", lat);
        #1 bus.req = '0;
        check("rr_count", dut_grants.size(), 4);
        check("rr_g0", dut_grants.size() > 0 ? dut_grants[0] : '0, 2'b01);
        check("rr_g1", dut_grants.size() > 1 ? dut_grants[1] : '0, 2'b10);
        check("rr_g2", dut_grants.size() > 2 ? dut_grants[2] : '0, 2'b01);
        check("rr_g3", dut_grants.size() > 3 ? dut_grants[3] : '0, 2'b10);

        bus.req_slv = {2'd2, 2'd0}; bus.req_data = {8'h77, 8'h3E}; bus.req = 2'b01;
        wait_grant("late");
        repeat (6) @(negedge clk);
        #1 bus.req = 2'b10;
        wait_done("late0", lat);
        check("late_drop_rx", bus.rx_data, 8'h17);
        wait_grant("late1");
        check("late_next_grant", bus.grant, 2'b10);
        wait_done("late1", lat);
        #1 bus.req = '0;
        check("late_rx", bus.rx_data, 8'h3C);

        bus.req_slv[1:0] = 2'd1; bus.req_data[7:0] = 8'h5A; bus.req = 2'b01;
        wait_grant("stab");
        #1 bus.req_data[7:0] = 8'hFF; bus.req_slv[1:0] = 2'd3;
        wait_done("stab", lat);
        #1 bus.req = '0;
        check("stab_mosi", last_mosi, 8'h5A);
        check("stab_rx", bus.rx_data, 8'hAA);

        bus.req_slv[1:0] = 2'd2; bus.req_data[7:0] = 8'hC3; bus.req = 2'b01;
        wait_grant("mid");
        n = 0;
        while (rises < 5 && n < 200) begin @(negedge clk); n++; end
        check("mid_bit4", rises, 5);
        #1 reset = 1'b0;
        #1;
        check("mid_cs", bus.CS, 4'hF);
        check("mid_sclk", bus.SCLK, 0);
        check("mid_grant", bus.grant, 0);
        check("mid_busy", bus.busy, 0);
        check("mid_done", bus.done, 0);
        bus.req = '0;
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;
        bus.req_slv[3:2] = 2'd3; bus.req_data[15:8] = 8'h81; bus.req = 2'b10;
        wait_grant("post");
        wait_done("post", lat);
        #1 bus.req = '0;
        check("post_rx", bus.rx_data, 8'hE4);
        check("post_mosi", last_mosi, 8'h81);

        bus.req_slv = {2'd1, 2'd1}; bus.req = 2'b11;
        wait_done("flush0", lat);
        check("flush_rx0", bus.rx_data, 8'hAA);
        wait_done("flush1", lat);
        #1 bus.req = '0;
        check("flush_rx1", bus.rx_data, 8'hAA);

        repeat (50) @(posedge clk);
        for (int s = 0; s < NS; s++) slv_byte[s] = 8'($urandom);
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #2;
            if ($urandom_range(0, 599) == 0) do_reset();
            for (int r = 0; r < NR; r++) if ($urandom_range(0, 7) == 0) bus.req[r] = ~bus.req[r];
            if ($urandom_range(0, 3) == 0) bus.req_data = 16'($urandom);
            if ($urandom_range(0, 3) == 0) bus.req_slv = RSW'($urandom);
        end
        bus.req = '0;
        repeat (60) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1);
    end
endmodule
